// File: rtl/fir_phase_sched.sv
// Polyphase FIR scheduler: sequences sample/coefficient addresses for I/D resampling.
// Define FIRSCHED_STATS_EN to build the out_cnt/ovf statistics; otherwise they read 0.
module fir_phase_sched #(
  parameter int NTAP = 8,
  parameter int AW   = 10
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    out_ready,
  output logic [AW-1:0]           samp_addr,
  output logic [$clog2(NTAP)+1:0] coef_addr,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    out_valid,
  output logic [1:0]              phase,
  output logic                    busy,
  output logic [15:0]             out_cnt,
  output logic                    ovf
);
  localparam int KW = $clog2(NTAP);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MAC, S_EMIT} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic            mode_q;
  logic            stop_pend_q;
  logic [1:0]      phase_q;
  logic [AW-1:0]   base_q;
  logic [AW:0]     level_q;
  logic            in_ready_q;
  logic            mac_en_q;
  logic            mac_clr_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [AW-1:0]   samp_addr_q;
  logic [KW+1:0]   coef_addr_q;

  logic            wr_s;
  logic            hs_s;
  logic [2:0]      sum_s;
  logic [2:0]      step_s;
  logic [2:0]      diff_s;
  logic [1:0]      adv_s;
  logic [1:0]      phase_d;
  logic [AW:0]     level_d;
  logic [KW-1:0]   k_d;
  logic [AW-1:0]   samp_d;
  logic [KW+1:0]   coef_d;

  // Phase advance (phase + D split into retire count and new phase), fill level, next tap addresses.
  always_comb begin
    wr_s   = in_valid & in_ready_q;
    hs_s   = out_valid_q & out_ready;
    sum_s  = {1'b0, phase_q} + (mode_q ? 3'd4 : 3'd3);
    adv_s  = 2'd0;
    step_s = 3'd0;
    if (hs_s) begin
      if (mode_q) begin
        if (sum_s >= 3'd6) begin
          adv_s  = 2'd2;
          step_s = 3'd6;
        end else if (sum_s >= 3'd3) begin
          adv_s  = 2'd1;
          step_s = 3'd3;
        end else begin
          adv_s  = 2'd0;
          step_s = 3'd0;
        end
      end else if (sum_s >= 3'd4) begin
        adv_s  = 2'd1;
        step_s = 3'd4;
      end else begin
        adv_s  = 2'd0;
        step_s = 3'd0;
      end
    end else begin
      adv_s  = 2'd0;
      step_s = 3'd0;
    end
    diff_s  = sum_s - step_s;
    phase_d = diff_s[1:0];
    level_d = level_q + {{AW{1'b0}}, wr_s} - {{(AW-1){1'b0}}, adv_s};
    k_d     = (state_q == S_MAC) ? (k_q + KW'(1)) : '0;
    samp_d  = base_q + AW'(NTAP - 1) - AW'(k_d);
    coef_d  = {phase_q, k_d};
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      phase_q     <= 2'd0;
      base_q      <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      samp_addr_q <= '0;
      coef_addr_q <= '0;
    end else begin
      level_q     <= level_d;
      in_ready_q  <= ~level_d[AW];
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      samp_addr_q <= '0;
      coef_addr_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_WAIT;
            mode_q      <= mode;
            phase_q     <= 2'd0;
            k_q         <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (stop) begin
            state_q <= S_IDLE;
            phase_q <= 2'd0;
            busy_q  <= 1'b0;
          end else if (level_q >= (AW+1)'(NTAP)) begin
            state_q     <= S_MAC;
            k_q         <= '0;
            mac_en_q    <= 1'b1;
            mac_clr_q   <= 1'b1;
            samp_addr_q <= samp_d;
            coef_addr_q <= coef_d;
          end
        end
        S_MAC: begin
          if (stop) stop_pend_q <= 1'b1;
          if (k_q == KW'(NTAP - 1)) begin
            state_q     <= S_EMIT;
            out_valid_q <= 1'b1;
          end else begin
            k_q         <= k_d;
            mac_en_q    <= 1'b1;
            samp_addr_q <= samp_d;
            coef_addr_q <= coef_d;
          end
        end
        S_EMIT: begin
          if (hs_s) begin
            out_valid_q <= 1'b0;
            base_q      <= base_q + AW'(adv_s);
            // A stop arriving on the handshake cycle still ends the run here.
            if (stop_pend_q | stop) begin
              state_q     <= S_IDLE;
              phase_q     <= 2'd0;
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              state_q <= S_WAIT;
              phase_q <= phase_d;
            end
          end else if (stop) begin
            stop_pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIRSCHED_STATS_EN
  logic [15:0] out_cnt_q;
  logic        ovf_q;

  // Delivered-output counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (r) begin
      out_cnt_q <= 16'd0;
      ovf_q     <= 1'b0;
    end else begin
      if (hs_s) out_cnt_q <= out_cnt_q + 16'd1;
      if (in_valid & ~in_ready_q) ovf_q <= 1'b1;
    end
  end

  assign out_cnt = out_cnt_q;
  assign ovf     = ovf_q;
`else
  assign out_cnt = 16'd0;
  assign ovf     = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign samp_addr = samp_addr_q;
  assign coef_addr = coef_addr_q;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign busy      = busy_q;

endmodule

// File: doc/fir_phase_sched.md
FIR_PHASE_SCHED -- requirements
Module: fir_phase_sched

Interface
REQ-001 SHALL have parameter NTAP, default 8, taps per polyphase branch (power of 2, 2..64).
REQ-002 SHALL have parameter AW, default 10, sample buffer address width.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- r  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begin run, latch mode.
- stop  in  1  pulse; end run after current output.
- mode  in  1  1: I=3,D=4; 0: I=4,D=3.
- in_valid  in  1  input sample written to buffer this cycle.
- in_ready  out  1  buffer can accept a sample.
- out_ready  in  1  downstream accepts output.
- samp_addr  out  AW  sample buffer read address.
- coef_addr  out  2+log2(NTAP)  coefficient ROM address.
- mac_clr  out  1  clear accumulator (first tap).
- mac_en  out  1  accumulate this cycle.
- out_valid  out  1  accumulator result valid.
- phase  out  2  current polyphase branch.
- busy  out  1  state != IDLE.
- out_cnt  out  16  outputs delivered (stats).
- ovf  out  1  sticky: in_valid while in_ready=0 (stats).

Function
REQ-004 SHALL implement FSM IDLE, WAIT, MAC, EMIT.
REQ-005 IDLE: start=1 -> WAIT; latch mode into I/D; phase=0, tap index k=0.
REQ-006 WAIT: level>=NTAP -> MAC; stop=1 -> IDLE.
REQ-007 MAC: exactly NTAP cycles, k=0..NTAP-1; mac_en=1 each cycle; mac_clr=1 only at k=0; then EMIT.
REQ-008 In MAC: samp_addr = base+NTAP-1-k mod 2^AW; coef_addr = phase*NTAP+k. Both 0 outside MAC.
REQ-009 EMIT: out_valid=1 from the cycle after the last MAC cycle, held until out_ready=1.
REQ-010 On out_valid&out_ready: s=phase+D; adv=floor(s/I) (0..2); phase<=s-adv*I; base<=base+adv mod 2^AW; then WAIT, or IDLE if stop is pending.
REQ-011 level (AW+1 bits) SHALL update as level+(in_valid&in_ready)-adv in one cycle; simultaneous write and retire is legal.
REQ-012 in_ready SHALL be level<2^AW; a write when in_ready=0 is dropped, level unchanged.
REQ-013 stop in MAC/EMIT SHALL set a pending flag; the current output completes, then IDLE. The flag clears on IDLE entry.
REQ-014 start outside IDLE and mode changes after latching SHALL be ignored. stop and start together in IDLE: start wins.
REQ-015 IDLE SHALL keep base and level, so a restart continues the sample stream; phase resets to 0.
REQ-016 busy SHALL be 1 in WAIT, MAC and EMIT.

Reset
REQ-017 With r=1 at a clock edge: state=IDLE; phase, k, base, level, stop-pending=0; all outputs 0 except in_ready=1; out_cnt=0, ovf=0.
REQ-018 Reset mid-run SHALL abort immediately with no trailing out_valid, and SHALL override start/stop/in_valid that cycle.

Configuration
REQ-019 Macro FIRSCHED_STATS_EN defined: out_cnt increments (wrapping) per out_valid&out_ready, and ovf is set per REQ-012 and cleared only by r.
REQ-020 Macro FIRSCHED_STATS_EN undefined: out_cnt and ovf ports still exist, tied to 0; no counter logic.

Verification
REQ-021 NTAP=8, mode=0, 8 samples preloaded, start, out_ready=1 -> mac_en for 8 cycles, samp_addr 7..0, coef_addr 0..7, then out_valid=1 one cycle later.
REQ-022 mode=0, continuous input -> phase sequence 0,3,2,1,0, adv sequence 0,1,1,1, base +3 after 4 outputs.
REQ-023 mode=1 -> phase 0,1,2,0, adv 1,1,2, base +4 after 3 outputs; coef_addr for phase 2 = 16..23.
REQ-024 out_ready=0 for 5 cycles in EMIT -> out_valid held 5+ cycles, phase/base unchanged until handshake; stop during MAC -> one output, then IDLE, busy=0.
REQ-025 AW=3, NTAP=2, stream 9 writes without outputs -> in_ready=0 after 8 writes; 9th write dropped; ovf=1 with FIRSCHED_STATS_EN, 0 without.
REQ-026 r=1 during MAC -> next cycle IDLE, all outputs reset values, no out_valid; restart -> phase=0, base=0.
